// File: rtl/rf_seq.sv
// rf_seq: sequences one read-execute-write operation against an external register file.
// Optional RF_SEQ_FLAGS_EN adds registered zero/carry flag outputs.
module rf_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [0:1]  op,
  input  logic [0:2]  src_a,
  input  logic [0:2]  src_b,
  input  logic [0:2]  dst,
  input  logic [0:15] rf_d_out_a,
  input  logic [0:15] rf_d_out_b,
  output logic [0:2]  rf_rd_addr_a,
  output logic [0:2]  rf_rd_addr_b,
  output logic        rf_wr,
  output logic [0:2]  rf_wr_addr,
  output logic [0:15] rf_d_in,
  output logic        busy,
  output logic        done,
  output logic [0:15] result
`ifdef RF_SEQ_FLAGS_EN
  ,
  output logic        zero,
  output logic        carry
`endif
);
  typedef enum logic [2:0] {IDLE, READ, EXEC, WRITE, DONE} state_t;
  state_t      state_q, state_d;
  logic [0:1]  op_q, op_d;
  logic [0:2]  src_a_q, src_a_d, src_b_q, src_b_d, dst_q, dst_d;
  logic [0:15] opa_q, opa_d, opb_q, opb_d, result_q, result_d;
  logic [0:16] alu;
  logic        zero_q, zero_d, carry_q, carry_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? READ : IDLE;
      READ:    state_d = EXEC;
      EXEC:    state_d = WRITE;
      WRITE:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  wire take = (state_q == IDLE) && start;
  // Bit 0 of alu is carry-out for ADD and borrow for SUB; always 0 for AND/MOV.
  always_comb begin
    alu = op_q == 2'b00 ? {1'b0, opa_q} + {1'b0, opb_q} :
          op_q == 2'b01 ? {1'b0, opa_q} - {1'b0, opb_q} :
          op_q == 2'b10 ? {1'b0, opa_q & opb_q} : {1'b0, opa_q};
    op_d     = take ? op    : op_q;
    src_a_d  = take ? src_a : src_a_q;
    src_b_d  = take ? src_b : src_b_q;
    dst_d    = take ? dst   : dst_q;
    opa_d    = state_q == READ ? rf_d_out_a : opa_q;
    opb_d    = state_q == READ ? rf_d_out_b : opb_q;
    result_d = state_q == EXEC ? alu[1:16] : result_q;
    zero_d   = state_q == EXEC ? alu[1:16] == 16'h0000 : zero_q;
    carry_d  = state_q == EXEC ? alu[0] : carry_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      src_a_q  <= '0;
      src_b_q  <= '0;
      dst_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      src_a_q  <= src_a_d;
      src_b_q  <= src_b_d;
      dst_q    <= dst_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
    end
  end
  assign rf_rd_addr_a = src_a_q;
  assign rf_rd_addr_b = src_b_q;
  assign rf_wr        = state_q == WRITE;
  assign rf_wr_addr   = dst_q;
  assign rf_d_in      = result_q;
  assign busy         = state_q != IDLE;
  assign done         = state_q == DONE;
  assign result       = result_q;
`ifdef RF_SEQ_FLAGS_EN
  assign zero  = zero_q;
  assign carry = carry_q;
`else
  wire unused_flags = zero_q ^ carry_q;
`endif
endmodule

// File: tb/tb_rf_seq.sv
// tb_rf_seq: directed bench for rf_seq against a behavioural 8x16 register file.
module tb_rf_seq;
  logic        clk = 1'b0, reset, start;
  logic [0:1]  op;
  logic [0:2]  src_a, src_b, dst, rf_rd_addr_a, rf_rd_addr_b, rf_wr_addr;
  logic [0:15] rf_d_out_a, rf_d_out_b, rf_d_in, result;
  logic        rf_wr, busy, done;
`ifdef RF_SEQ_FLAGS_EN
  logic        zero, carry;
`endif
  logic [0:15] rf [8];
  logic        pre_we;
  logic [0:2]  pre_addr;
  logic [0:15] pre_data;
  int vectors = 0, miscompares = 0;
  int wr_cyc, done_cyc, wr_cnt, done_cnt;
  logic [0:2]  wr_addr, rd_a, rd_b;
  logic [0:15] wr_data;

  rf_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .src_a(src_a), .src_b(src_b), .dst(dst),
    .rf_d_out_a(rf_d_out_a), .rf_d_out_b(rf_d_out_b), .rf_rd_addr_a(rf_rd_addr_a),
    .rf_rd_addr_b(rf_rd_addr_b), .rf_wr(rf_wr), .rf_wr_addr(rf_wr_addr), .rf_d_in(rf_d_in),
    .busy(busy), .done(done), .result(result)
`ifdef RF_SEQ_FLAGS_EN
    , .zero(zero), .carry(carry)
`endif
  );

  always #5 clk = ~clk;
  assign rf_d_out_a = rf[rf_rd_addr_a];
  assign rf_d_out_b = rf[rf_rd_addr_b];
  always @(posedge clk)
    if (rf_wr) rf[rf_wr_addr] <= rf_d_in;
    else if (pre_we) rf[pre_addr] <= pre_data;

  task preload(input logic [0:2] a, input logic [0:15] v);
    @(negedge clk); pre_we = 1'b1; pre_addr = a; pre_data = v;
    @(negedge clk); pre_we = 1'b0;
  endtask

  // Issues one command and records what happens over the next 8 cycles.
  // With noise, start is re-pulsed with scrambled fields during READ, EXEC and WRITE.
  task run_cmd(input logic [0:1] o, input logic [0:2] a, input logic [0:2] b, input logic [0:2] d, input bit noise);
    wr_cyc = -1; done_cyc = -1; wr_cnt = 0; done_cnt = 0;
    @(negedge clk); op = o; src_a = a; src_b = b; dst = d; start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = noise && c <= 3;
      if (noise) begin op = ~o; src_a = ~a; src_b = ~b; dst = ~d; end
      if (c == 1) begin rd_a = rf_rd_addr_a; rd_b = rf_rd_addr_b; end
      if (rf_wr) begin wr_cnt++; wr_cyc = c; wr_addr = rf_wr_addr; wr_data = rf_d_in; end
      if (done) begin done_cnt++; done_cyc = c; end
    end
  endtask

  task test_reset;
    #1;
    vectors++; if ({busy, done, rf_wr} !== 3'b000) begin miscompares++; $display("FAIL reset_ctrl: got %b want 000", {busy, done, rf_wr}); end
    vectors++; if ({rf_rd_addr_a, rf_rd_addr_b, rf_wr_addr} !== 9'd0) begin miscompares++; $display("FAIL reset_addr: got %h want 0", {rf_rd_addr_a, rf_rd_addr_b, rf_wr_addr}); end
    vectors++; if ({rf_d_in, result} !== 32'd0) begin miscompares++; $display("FAIL reset_data: got %h want 0", {rf_d_in, result}); end
    @(negedge clk); reset = 1'b0;
  endtask

  task test_add;
    preload(3'd1, 16'h0005); preload(3'd2, 16'h0003);
    run_cmd(2'b00, 3'd1, 3'd2, 3'd3, 1'b0);
    vectors++; if (wr_cyc !== 3) begin miscompares++; $display("FAIL add_wr_latency: got %0d want 3", wr_cyc); end
    vectors++; if (done_cyc !== 4) begin miscompares++; $display("FAIL add_done_latency: got %0d want 4", done_cyc); end
    vectors++; if (rd_a !== 3'd1 || rd_b !== 3'd2) begin miscompares++; $display("FAIL add_rd_addr: got %0d/%0d want 1/2", rd_a, rd_b); end
    vectors++; if (wr_addr !== 3'd3) begin miscompares++; $display("FAIL add_wr_addr: got %0d want 3", wr_addr); end
    vectors++; if (rf[3] !== 16'h0008) begin miscompares++; $display("FAIL add_r3: got %h want 0008", rf[3]); end
    vectors++; if (result !== 16'h0008) begin miscompares++; $display("FAIL add_result: got %h want 0008", result); end
`ifdef RF_SEQ_FLAGS_EN
    vectors++; if ({zero, carry} !== 2'b00) begin miscompares++; $display("FAIL add_flags: got %b want 00", {zero, carry}); end
`endif
  endtask

  task test_sub;
    preload(3'd1, 16'h0000); preload(3'd2, 16'h0001);
    run_cmd(2'b01, 3'd1, 3'd2, 3'd4, 1'b0);
    vectors++; if (rf[4] !== 16'hFFFF) begin miscompares++; $display("FAIL sub_r4: got %h want ffff", rf[4]); end
    vectors++; if (wr_cnt !== 1 || done_cnt !== 1) begin miscompares++; $display("FAIL sub_pulses: got %0d/%0d want 1/1", wr_cnt, done_cnt); end
`ifdef RF_SEQ_FLAGS_EN
    vectors++; if ({zero, carry} !== 2'b01) begin miscompares++; $display("FAIL sub_flags: got %b want 01", {zero, carry}); end
`endif
  endtask

  task test_and_mov;
    preload(3'd5, 16'hF0F0);
    run_cmd(2'b10, 3'd5, 3'd5, 3'd5, 1'b0);
    vectors++; if (rf[5] !== 16'hF0F0) begin miscompares++; $display("FAIL and_r5: got %h want f0f0", rf[5]); end
    preload(3'd0, 16'h1234);
    run_cmd(2'b11, 3'd0, 3'd5, 3'd5, 1'b0);
    vectors++; if (rf[5] !== 16'h1234) begin miscompares++; $display("FAIL mov_r5: got %h want 1234", rf[5]); end
`ifdef RF_SEQ_FLAGS_EN
    vectors++; if ({zero, carry} !== 2'b00) begin miscompares++; $display("FAIL mov_flags: got %b want 00", {zero, carry}); end
`endif
  endtask

  task test_wrap;
    preload(3'd6, 16'hFFFF); preload(3'd7, 16'h0001);
    run_cmd(2'b00, 3'd6, 3'd7, 3'd6, 1'b0);
    vectors++; if (rf[6] !== 16'h0000) begin miscompares++; $display("FAIL wrap_r6: got %h want 0000", rf[6]); end
`ifdef RF_SEQ_FLAGS_EN
    vectors++; if ({zero, carry} !== 2'b11) begin miscompares++; $display("FAIL wrap_flags: got %b want 11", {zero, carry}); end
`endif
  endtask

  task test_busy_ignore;
    preload(3'd1, 16'h0010); preload(3'd2, 16'h0004);
    run_cmd(2'b01, 3'd1, 3'd2, 3'd2, 1'b1);
    vectors++; if (wr_cnt !== 1 || done_cnt !== 1) begin miscompares++; $display("FAIL busy_pulses: got %0d/%0d want 1/1", wr_cnt, done_cnt); end
    vectors++; if (wr_cyc !== 3 || done_cyc !== 4) begin miscompares++; $display("FAIL busy_latency: got %0d/%0d want 3/4", wr_cyc, done_cyc); end
    vectors++; if (rd_a !== 3'd1 || rd_b !== 3'd2) begin miscompares++; $display("FAIL busy_rd_addr: got %0d/%0d want 1/2", rd_a, rd_b); end
    vectors++; if (wr_addr !== 3'd2 || wr_data !== 16'h000C) begin miscompares++; $display("FAIL busy_write: got %0d/%h want 2/000c", wr_addr, wr_data); end
    vectors++; if (rf[2] !== 16'h000C) begin miscompares++; $display("FAIL busy_r2: got %h want 000c", rf[2]); end
    vectors++; if (rf_wr_addr !== 3'd2 || rf_d_in !== 16'h000C || busy !== 1'b0) begin miscompares++; $display("FAIL busy_hold: got %0d/%h/%b want 2/000c/0", rf_wr_addr, rf_d_in, busy); end
  endtask

  task test_reset_write;
    int dn;
    preload(3'd1, 16'h1111); preload(3'd2, 16'h2222);
    @(negedge clk); op = 2'b00; src_a = 3'd1; src_b = 3'd2; dst = 3'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (rf_wr !== 1'b1) begin miscompares++; $display("FAIL rstw_in_write: got %b want 1", rf_wr); end
    #1 reset = 1'b1;
    #1;
    vectors++; if ({rf_wr, busy, done} !== 3'b000) begin miscompares++; $display("FAIL rstw_async: got %b want 000", {rf_wr, busy, done}); end
    vectors++; if ({result, rf_d_in} !== 32'd0 || rf_wr_addr !== 3'd0) begin miscompares++; $display("FAIL rstw_clear: got %h/%0d want 0/0", {result, rf_d_in}, rf_wr_addr); end
    @(negedge clk); reset = 1'b0;
    dn = 0;
    repeat (4) begin @(negedge clk); if (done) dn++; end
    vectors++; if (dn !== 0) begin miscompares++; $display("FAIL rstw_no_done: got %0d want 0", dn); end
    vectors++; if (rf[3] !== 16'h0008) begin miscompares++; $display("FAIL rstw_r3_kept: got %h want 0008", rf[3]); end
    run_cmd(2'b00, 3'd1, 3'd2, 3'd3, 1'b0);
    vectors++; if (rf[3] !== 16'h3333 || wr_cyc !== 3 || done_cyc !== 4) begin miscompares++; $display("FAIL rstw_recover: got %h/%0d/%0d want 3333/3/4", rf[3], wr_cyc, done_cyc); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; src_a = '0; src_b = '0; dst = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    test_reset;
    test_add;
    test_sub;
    test_and_mov;
    test_wrap;
    test_busy_ignore;
    test_reset_write;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rf_seq.md
RF_SEQ -- requirements
Module: rf_seq

Interface
REQ-001 SHALL have no parameters; widths are fixed: register address 3 bits, data 16 bits, bit 0 is the MSB of every vector ([0:N] ordering).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 op  input  [0:1]  operation code: 00 ADD, 01 SUB, 10 AND, 11 MOV (pass A).
REQ-006 src_a, src_b  input  [0:2] each  source register addresses.
REQ-007 dst  input  [0:2]  destination register address.
REQ-008 rf_d_out_a, rf_d_out_b  input  [0:15] each  combinational read data returned by the register file.
REQ-009 rf_rd_addr_a, rf_rd_addr_b  output  [0:2] each  read addresses driven to the register file.
REQ-010 rf_wr  output  1  register-file write enable.
REQ-011 rf_wr_addr  output  [0:2]  write address.
REQ-012 rf_d_in  output  [0:15]  write data.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 result  output  [0:15]  last computed value, held until the next EXEC.

Function
REQ-016 SHALL implement the FSM IDLE -> READ -> EXEC -> WRITE -> DONE -> IDLE, with exactly one cycle in each non-IDLE state.
REQ-017 IDLE with start=1 at a clock edge: latch op, src_a, src_b and dst into command registers; next state READ.
REQ-018 IDLE with start=0: remain in IDLE.
REQ-019 rf_rd_addr_a/b SHALL always drive the latched src_a/src_b.
REQ-020 READ: capture rf_d_out_a and rf_d_out_b into operand registers at the end of the cycle.
REQ-021 EXEC: compute from the operand registers into the result register.
  - ADD: (A+B) mod 2^16.
  - SUB: (A-B) mod 2^16.
  - AND: bitwise A&B.
  - MOV: A.
REQ-022 WRITE: rf_wr=1, rf_wr_addr=latched dst, rf_d_in=result. rf_wr SHALL be 0 in every other state.
REQ-023 DONE: done=1 for exactly one cycle.
REQ-024 Latency: with start sampled at edge N, rf_wr is high in cycle N+3 and done is high in cycle N+4. The next start is accepted at edge N+5.
REQ-025 start SHALL be ignored while busy=1, and the command registers SHALL not change while busy=1.
REQ-026 rf_wr_addr and rf_d_in SHALL hold their values outside WRITE (latched dst and result).
REQ-027 dst equal to src_a or src_b SHALL be legal; operands are captured before the write, so the old value is used.
REQ-028 Overflow, borrow and wrap-around SHALL be silently truncated to 16 bits.

Reset
REQ-029 reset=1 SHALL immediately force IDLE and clear all command, operand and result registers to 0, without waiting for a clock edge.
REQ-030 Output values during and after reset SHALL be: busy=0, done=0, rf_wr=0, all address outputs 0, rf_d_in=0, result=0.
REQ-031 Reset asserted mid-operation, including in WRITE, SHALL deassert rf_wr immediately and abort the write; no done pulse SHALL follow.

Configuration
REQ-032 Macro RF_SEQ_FLAGS_EN defined: add output ports zero (1 bit) and carry (1 bit), both registered in EXEC alongside result and reset to 0.
  - zero = (result == 0).
  - carry = carry-out for ADD, borrow for SUB, 0 for AND and MOV.
REQ-033 Macro RF_SEQ_FLAGS_EN undefined: the zero and carry ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-034 Bench SHALL connect rf_seq to a behavioural 8x16 register file model and cover these directed scenarios:
  - Preload R1=0x0005, R2=0x0003; start ADD src_a=1 src_b=2 dst=3 -> rf_wr high exactly 3 cycles after start, R3=0x0008, done one cycle later.
  - R1=0x0000, R2=0x0001; SUB src_a=1 src_b=2 dst=4 -> R4=0xFFFF; with RF_SEQ_FLAGS_EN, carry=1 and zero=0.
  - R5=0xF0F0; AND src_a=5 src_b=5 dst=5 -> R5=0xF0F0. Then MOV src_a=0 dst=5 with R0=0x1234 -> R5=0x1234.
  - R6=0xFFFF, R7=0x0001; ADD dst=6 -> R6=0x0000; with RF_SEQ_FLAGS_EN, zero=1 and carry=1.
  - Pulse start with different fields during READ, EXEC and WRITE -> ignored; the original command completes; exactly one rf_wr pulse and one done pulse.
  - Assert reset during WRITE -> rf_wr drops asynchronously, destination register unchanged, busy=0, done never pulses; the next start completes normally.
